// File: rtl/button_bank.sv
// button_bank: per-channel 2-flop synchroniser, debouncer and registered press/release pulses.
// Define BUTTON_REPEAT_EN to add auto-repeat press pulses while a button stays held.
module button_bank #(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned DEB_CYCLES    = 16,
  parameter int unsigned REPEAT_DELAY  = 1000,
  parameter int unsigned REPEAT_PERIOD = 200
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic [N_BTN-1:0] iExtBtn,
  output logic [N_BTN-1:0] oIntBtn,
  output logic [N_BTN-1:0] oRelBtn,
  output logic [N_BTN-1:0] oLevel
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEB_CYCLES);

  if (N_BTN < 1 || N_BTN > 32 || DEB_CYCLES < 1 || DEB_CYCLES > (1 << 20) ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_bank: parameter out of range");
  end

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] level_d;
  logic [N_BTN-1:0] int_d;
  logic [N_BTN-1:0] rel_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];

`ifdef BUTTON_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  logic [RPT_W-1:0] rpt_q [N_BTN];
  logic [RPT_W-1:0] rpt_d [N_BTN];
`endif

  // Debounce / pulse next-state; pins are active-low, so sync == level means disagreement.
  always_comb begin
    level_d = oLevel;
    int_d   = '0;
    rel_d   = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
`ifdef BUTTON_REPEAT_EN
      rpt_d[i] = '0;
`endif
      if (cnt_q[i] == CNT_DONE) begin
        level_d[i] = ~oLevel[i];
        int_d[i]   = ~oLevel[i];
        rel_d[i]   = oLevel[i];
`ifdef BUTTON_REPEAT_EN
        if (!oLevel[i]) rpt_d[i] = RPT_W'(REPEAT_DELAY - 1);
`endif
      end else begin
        if (sync2_q[i] == oLevel[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
`ifdef BUTTON_REPEAT_EN
        // Down-counter reloads on each repeat pulse; idles at zero while released.
        if (oLevel[i]) begin
          if (rpt_q[i] == '0) begin
            int_d[i] = 1'b1;
            rpt_d[i] = RPT_W'(REPEAT_PERIOD - 1);
          end else begin
            rpt_d[i] = rpt_q[i] - RPT_W'(1);
          end
        end
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      sync1_q <= '1;
      sync2_q <= '1;
      oLevel  <= '0;
      oIntBtn <= '0;
      oRelBtn <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
`ifdef BUTTON_REPEAT_EN
        rpt_q[i] <= '0;
`endif
      end
    end else begin
      sync1_q <= iExtBtn;
      sync2_q <= sync1_q;
      oLevel  <= level_d;
      oIntBtn <= int_d;
      oRelBtn <= rel_d;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
`ifdef BUTTON_REPEAT_EN
        rpt_q[i] <= rpt_d[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_button_bank.sv
// Bench for button_bank: directed scenarios plus randomized pins against a timeline-based model.
module tb_button_bank;

  localparam int unsigned N   = 4;
  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 20;
  localparam int unsigned RP  = 8;
  localparam int MAXC = 4096;
`ifdef BUTTON_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic         CLK;
  logic         RESETn;
  logic [N-1:0] iExtBtn;
  logic [N-1:0] oIntBtn;
  logic [N-1:0] oRelBtn;
  logic [N-1:0] oLevel;

  button_bank #(
    .N_BTN(N), .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLK(CLK), .RESETn(RESETn), .iExtBtn(iExtBtn),
    .oIntBtn(oIntBtn), .oRelBtn(oRelBtn), .oLevel(oLevel)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: pin timeline per edge; the logic sees the pin from two edges back (or 1 after reset).
  logic [N-1:0] hist [MAXC];
  bit           rst_at [MAXC];
  int           cyc = 0;
  int           run [N];
  int           press_t [N];
  logic [N-1:0] acc, e_int, e_rel;

  task automatic model_edge(input logic rstn, input logic [N-1:0] pins);
    logic [N-1:0] seen;
    bit flipped;
    int d;
    rst_at[cyc % MAXC] = !rstn;
    hist[cyc % MAXC]   = rstn ? pins : '1;
    e_int = '0;
    e_rel = '0;
    if (!rstn) begin
      acc = '0;
      for (int ch = 0; ch < N; ch++) run[ch] = 0;
    end else begin
      seen = (cyc < 2 || rst_at[(cyc - 1) % MAXC]) ? '1 : hist[(cyc - 2) % MAXC];
      for (int ch = 0; ch < N; ch++) begin
        flipped = 1'b0;
        if (run[ch] == int'(DEB)) begin
          acc[ch] = ~acc[ch];
          run[ch] = 0;
          flipped = 1'b1;
          if (acc[ch]) begin
            e_int[ch]   = 1'b1;
            press_t[ch] = cyc;
          end else begin
            e_rel[ch] = 1'b1;
          end
        end else if ((!seen[ch]) != acc[ch]) begin
          run[ch]++;
        end else begin
          run[ch] = 0;
        end
        if (REP_ON && !flipped && acc[ch]) begin
          d = cyc - press_t[ch];
          if (d >= int'(RD) && ((d - int'(RD)) % int'(RP)) == 0) e_int[ch] = 1'b1;
        end
      end
    end
    cyc++;
  endtask

  task automatic step(input logic rstn, input logic [N-1:0] pins);
    RESETn  = rstn;
    iExtBtn = pins;
    @(posedge CLK);
    model_edge(rstn, pins);
    @(negedge CLK);
    check("level", 32'(oLevel), 32'(acc));
    check("int", 32'(oIntBtn), 32'(e_int));
    check("rel", 32'(oRelBtn), 32'(e_rel));
  endtask

  initial begin
    int e0, pat, lat, n_i, n_r, first_v, ng;
    int got_off [8];
    int exp_off [6];
    int hold [N];
    logic [N-1:0] pins;
    exp_off = '{0, 20, 28, 36, 44, 52};
    acc = '0; e_int = '0; e_rel = '0;
    for (int ch = 0; ch < N; ch++) begin run[ch] = 0; press_t[ch] = 0; hold[ch] = 0; end

    // Reset and quiet period
    for (int k = 0; k < 3; k++) step(1'b0, 4'hF);
    check("rst_out", 32'({oIntBtn, oRelBtn, oLevel}), 32'd0);
    for (int k = 0; k < 50; k++) begin
      step(1'b1, 4'hF);
      check("quiet", 32'({oIntBtn, oRelBtn, oLevel}), 32'd0);
    end

    // Clean press and release on ch0
    e0 = cyc; lat = -1; n_i = 0; n_r = 0;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 4'b1110);
      if (oIntBtn[0]) begin if (lat < 0) lat = cyc - 1 - e0; n_i++; end
      if (oRelBtn[0]) n_r++;
    end
    check("press_lat", 32'(lat), 32'(DEB + 2));
    check("press_cnt", 32'(n_i), 32'd1);
    check("press_norel", 32'(n_r), 32'd0);
    check("press_lvl", 32'(oLevel), 32'b0001);
    e0 = cyc; lat = -1; n_r = 0;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 4'hF);
      if (oRelBtn[0]) begin if (lat < 0) lat = cyc - 1 - e0; n_r++; end
    end
    check("rel_lat", 32'(lat), 32'(DEB + 2));
    check("rel_cnt", 32'(n_r), 32'd1);

    // Glitches on ch1
    n_i = 0;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        step(1'b1, (k < 3) ? 4'b1101 : 4'b1111);
        if (oIntBtn[1] || oRelBtn[1] || oLevel[1]) n_i++;
      end
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 4'hF);
      if (oIntBtn[1] || oRelBtn[1] || oLevel[1]) n_i++;
    end
    check("glitch_quiet", 32'(n_i), 32'd0);

    // Simultaneous press/release of ch2 and ch3
    n_i = 0; first_v = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 4'b0011);
      if (oIntBtn != 4'b0000) begin if (n_i == 0) first_v = 32'(oIntBtn); n_i++; end
    end
    check("sim_press_val", 32'(first_v), 32'b1100);
    check("sim_press_cnt", 32'(n_i), 32'd1);
    n_r = 0; first_v = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 4'hF);
      if (oRelBtn != 4'b0000) begin if (n_r == 0) first_v = 32'(oRelBtn); n_r++; end
    end
    check("sim_rel_val", 32'(first_v), 32'b1100);
    check("sim_rel_cnt", 32'(n_r), 32'd1);

    // Reset in the middle of a ch0 debounce (counter at 2)
    n_i = 0;
    for (int k = 0; k < 4; k++) step(1'b1, 4'b1110);
    step(1'b0, 4'b1110);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 4'hF);
      if (oIntBtn[0] || oRelBtn[0] || oLevel[0]) n_i++;
    end
    check("mid_rst_quiet", 32'(n_i), 32'd0);

    // Button held through reset release
    step(1'b0, 4'b1110);
    step(1'b0, 4'b1110);
    e0 = cyc; lat = -1; n_i = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 4'b1110);
      if (oIntBtn[0]) begin if (lat < 0) lat = cyc - 1 - e0; n_i++; end
    end
    check("rst_hold_lat", 32'(lat), 32'(DEB + 2));
    check("rst_hold_cnt", 32'(n_i), 32'd1);
    for (int k = 0; k < 12; k++) step(1'b1, 4'hF);

    // Auto-repeat on ch0: held 60 cycles, then released
    e0 = cyc; ng = 0; pat = -1;
    for (int k = 0; k < 80; k++) begin
      step(1'b1, (k < 60) ? 4'b1110 : 4'b1111);
      if (oIntBtn[0]) begin
        if (pat < 0) pat = cyc - 1;
        if (ng < 8) got_off[ng] = cyc - 1 - pat;
        ng++;
      end
    end
    check("rpt_first", 32'(pat - e0), 32'(DEB + 2));
    check("rpt_count", 32'(ng), REP_ON ? 32'd6 : 32'd1);
    for (int i = 0; i < 6 && i < ng; i++) check("rpt_off", 32'(got_off[i]), 32'(exp_off[i]));

    // Randomized pins with occasional reset
    pins = 4'hF;
    for (int k = 0; k < 1500; k++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (hold[ch] == 0) begin
          pins[ch] = 1'($urandom_range(0, 1));
          hold[ch] = int'($urandom_range(1, 30));
        end
        hold[ch]--;
      end
      step(($urandom_range(0, 299) != 0), pins);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
